// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide data types shared by every pipeline stage.
package cpu_types_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
package fetch_stage_pkg;
   import cpu_types_pkg::*;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PEND   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

   // Sequential PC advance; wraps modulo 2^32 by construction.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect capture FSM and the IF/ID latch
// feeding decode (instru / nPCIn / valid).
module fetch_stage
   import cpu_types_pkg::*;
   import fetch_stage_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  ihit,
   input  word_t imemload,
   input  logic  stall,
   input  logic  flush,
   input  logic  redirect,
   input  word_t PCSrc,
   input  logic  halt,
   output logic  imemREN,
   output word_t imemaddr,
   output word_t instru,
   output word_t nPCIn,
   output logic  valid
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        pend_pc_q, pend_pc_d;
   word_t        instru_q, instru_d;
   word_t        npc_q, npc_d;
   logic         valid_q, valid_d;
   word_t        pc_inc;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         pend_pc_q <= '0;
         instru_q  <= '0;
         npc_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         instru_q  <= instru_d;
         npc_q     <= npc_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      instru_d  = instru_q;
      npc_d     = npc_q;
      valid_d   = valid_q;
      pc_inc    = pc_plus4(pc_q);

      if (halt) begin
         state_d  = HALTED;
         instru_d = '0;
         valid_d  = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               // A redirect that cannot be applied this edge is parked in pend_pc.
               if (redirect && (stall || !ihit)) begin
                  pend_pc_d = PCSrc;
                  state_d   = PEND;
               end
               if (!stall) begin
                  if (ihit) begin
                     pc_d     = redirect ? PCSrc : pc_inc;
                     instru_d = imemload;
                     npc_d    = pc_inc;
                     valid_d  = 1'b1;
                  end else begin
                     instru_d = '0;
                     valid_d  = 1'b0;
                  end
               end
            end
            PEND: begin
               // Whatever arrives here is wrong-path, so the latch only ever takes bubbles.
               if (redirect) begin
                  pend_pc_d = PCSrc;
               end else if (ihit && !stall) begin
                  pc_d    = pend_pc_q;
                  state_d = RUN;
               end
               if (!stall) begin
                  instru_d = '0;
                  valid_d  = 1'b0;
               end
            end
            HALTED: begin
               instru_d = '0;
               valid_d  = 1'b0;
            end
            default: begin
               state_d = RUN;
            end
         endcase

         if (flush) begin
            instru_d = '0;
            valid_d  = 1'b0;
         end
      end
   end

   assign imemaddr = pc_q;
   assign imemREN  = (state_q != HALTED);
   assign instru   = instru_q;
   assign nPCIn    = npc_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: hand-computed PC / latch values per scenario.
module tb_fetch_stage;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  nRST, ihit, stall, flush, redirect, halt;
   word_t imemload, PCSrc;

   logic  imemREN, imemREN_w;
   word_t imemaddr, instru, nPCIn, imemaddr_w, instru_w, nPCIn_w;
   logic  valid, valid_w;

   int    n_checks = 0;
   int    n_fail   = 0;

   fetch_stage dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
      .flush(flush), .redirect(redirect), .PCSrc(PCSrc), .halt(halt),
      .imemREN(imemREN), .imemaddr(imemaddr), .instru(instru), .nPCIn(nPCIn),
      .valid(valid)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
      .flush(flush), .redirect(redirect), .PCSrc(PCSrc), .halt(halt),
      .imemREN(imemREN_w), .imemaddr(imemaddr_w), .instru(instru_w), .nPCIn(nPCIn_w),
      .valid(valid_w)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One rising edge, then return on the falling edge where outputs are sampled.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic idle_inputs();
      ihit = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; halt = 1'b0;
      imemload = 32'h2001_0005; PCSrc = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      nRST = 1'b0;
      tick(1);
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b1;
      idle_inputs();
      @(negedge CLK);

      // Reset state
      do_reset();
      check("rst_pc", imemaddr, 32'h0);
      check("rst_ren", {31'b0, imemREN}, 32'd1);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_instru", instru, 32'h0);
      check("rst_npc", nPCIn, 32'h0);
      check("rst_wrap_pc", imemaddr_w, 32'hFFFF_FFFC);

      // Straight-line fetch and PC wrap on the second instance
      ihit = 1'b1;
      tick(1);
      check("seq1_pc", imemaddr, 32'h4);
      check("seq1_instru", instru, 32'h2001_0005);
      check("wrap_pc", imemaddr_w, 32'h0);
      check("wrap_npc", nPCIn_w, 32'h0);
      tick(2);
      check("seq3_pc", imemaddr, 32'hC);
      check("seq3_npc", nPCIn, 32'hC);
      check("seq3_valid", {31'b0, valid}, 32'd1);

      // Redirect with hit, then flush
      tick(13);
      check("at40_pc", imemaddr, 32'h40);
      redirect = 1'b1; PCSrc = 32'h100; imemload = 32'hAAAA_0001;
      tick(1);
      check("redir_pc", imemaddr, 32'h100);
      check("redir_npc", nPCIn, 32'h44);
      check("redir_valid", {31'b0, valid}, 32'd1);
      redirect = 1'b0; flush = 1'b1;
      tick(1);
      check("flush_valid", {31'b0, valid}, 32'd0);
      check("flush_instru", instru, 32'h0);
      check("flush_pc", imemaddr, 32'h104);
      flush = 1'b0;

      // Redirect on miss -> PEND, applied on the next hit
      do_reset();
      imemload = 32'h1111_2222; ihit = 1'b1;
      tick(16);
      ihit = 1'b0; redirect = 1'b1; PCSrc = 32'h200;
      tick(1);
      check("pend_pc_hold", imemaddr, 32'h40);
      check("pend_valid", {31'b0, valid}, 32'd0);
      redirect = 1'b0;
      tick(1);
      check("pend_miss_pc", imemaddr, 32'h40);
      check("pend_npc_held", nPCIn, 32'h40);
      ihit = 1'b1;
      tick(1);
      check("pend_apply_pc", imemaddr, 32'h200);
      check("pend_apply_valid", {31'b0, valid}, 32'd0);
      check("pend_apply_instru", instru, 32'h0);
      tick(1);
      check("run_again_pc", imemaddr, 32'h204);
      check("run_again_npc", nPCIn, 32'h204);
      check("run_again_valid", {31'b0, valid}, 32'd1);

      // Latest redirect wins while pending
      do_reset();
      ihit = 1'b1;
      tick(16);
      ihit = 1'b0; redirect = 1'b1; PCSrc = 32'h300;
      tick(1);
      ihit = 1'b1; PCSrc = 32'h400;
      tick(1);
      check("pend2_pc_hold", imemaddr, 32'h40);
      redirect = 1'b0;
      tick(1);
      check("pend2_latest", imemaddr, 32'h400);

      // Stall holds everything; stall+flush bubbles
      do_reset();
      imemload = 32'hCAFE_0001; ihit = 1'b1;
      tick(2);
      imemload = 32'hDEAD_BEEF; stall = 1'b1;
      tick(3);
      check("stall_pc", imemaddr, 32'h8);
      check("stall_instru", instru, 32'hCAFE_0001);
      check("stall_npc", nPCIn, 32'h8);
      check("stall_valid", {31'b0, valid}, 32'd1);
      flush = 1'b1;
      tick(1);
      check("stallflush_valid", {31'b0, valid}, 32'd0);
      check("stallflush_instru", instru, 32'h0);
      check("stallflush_pc", imemaddr, 32'h8);
      stall = 1'b0; flush = 1'b0; ihit = 1'b0;
      tick(1);
      check("miss_pc", imemaddr, 32'h8);
      check("miss_npc", nPCIn, 32'h8);

      // Halt at 0x80, only reset leaves it
      do_reset();
      ihit = 1'b1;
      tick(32);
      check("at80_pc", imemaddr, 32'h80);
      halt = 1'b1;
      tick(1);
      halt = 1'b0;
      check("halt_ren", {31'b0, imemREN}, 32'd0);
      check("halt_valid", {31'b0, valid}, 32'd0);
      tick(10);
      check("halt_pc10", imemaddr, 32'h80);
      check("halt_ren10", {31'b0, imemREN}, 32'd0);
      nRST = 1'b0;
      tick(1);
      check("halt_rst_pc", imemaddr, 32'h0);
      check("halt_rst_ren", {31'b0, imemREN}, 32'd1);
      nRST = 1'b1;
      tick(1);
      check("post_halt_pc", imemaddr, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 ihit  input  1  imemload valid for imemaddr this cycle.
REQ-005 imemload  input  32 (word_t)  instruction returned by icache.
REQ-006 stall  input  1  hazard hold; freeze PC and IF/ID latch.
REQ-007 flush  input  1  squash IF/ID latch contents (insert bubble).
REQ-008 redirect  input  1  branch/jump taken; next fetch from PCSrc.
REQ-009 PCSrc  input  32 (word_t)  redirect target.
REQ-010 halt  input  1  halt seen downstream; stop fetching.
REQ-011 imemREN  output  1  instruction read request.
REQ-012 imemaddr  output  32 (word_t)  current PC.
REQ-013 instru  output  32 (word_t)  latched instruction to decode.
REQ-014 nPCIn  output  32 (word_t)  latched PC+4 of instru.
REQ-015 valid  output  1  instru is a real, non-squashed instruction.

Function
REQ-016 States RUN, PEND (redirect captured, not yet applied), HALTED; fetch_state_t.
REQ-017 imemaddr SHALL equal the PC register combinationally; imemREN = 1 in RUN/PEND, 0 in HALTED.
REQ-018 PC+4 SHALL be 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0.
REQ-019 RUN, ihit=1, stall=0, redirect=0: PC<=PC+4; instru<=imemload; nPCIn<=PC+4; valid<=1.
REQ-020 RUN, ihit=1, stall=0, redirect=1: PC<=PCSrc; latch updated as REQ-019 (delay-slot-free: flush from downstream squashes it).
REQ-021 RUN, redirect=1 with ihit=0 or stall=1: pend_pc<=PCSrc; go PEND; PC unchanged.
REQ-022 PEND, ihit=1, stall=0: PC<=pend_pc; instru<=0; valid<=0 (wrong-path fetch discarded); go RUN.
REQ-023 PEND, new redirect: pend_pc<=PCSrc (latest wins), stay PEND.
REQ-024 ihit=0, no stall: latch SHALL load instru=0, valid=0, nPCIn unchanged (bubble); PC held.
REQ-025 stall=1, flush=0: PC, instru, nPCIn, valid held regardless of ihit.
REQ-026 flush=1: instru<=0, valid<=0 next edge, overriding stall and ihit; PC update per REQ-019..023 unaffected.
REQ-027 halt=1 in any state: go HALTED next edge; PC held; latch loads bubble; only reset exits HALTED.
REQ-028 Priority: nRST > halt > flush (latch) > stall > redirect > ihit.

Reset
REQ-029 nRST=0 at a rising edge: PC<=RESET_PC, state<=RUN, pend_pc<=0, instru<=0, nPCIn<=0, valid<=0.
REQ-030 Reset mid-PEND or mid-HALTED SHALL discard pending redirect and resume fetch at RESET_PC.
REQ-031 During reset cycles imemREN SHALL be 1 and imemaddr RESET_PC after the first reset edge.

Structure
REQ-032 word_t from cpu_types_pkg; fetch_state_t and RESET_PC default belong in the shared pipeline package.
REQ-033 Outputs instru/nPCIn/valid SHALL drive the decode_write_back_if dp-side nPCIn/instru signals directly.
REQ-034 No sub-modules; single module, one state register block plus combinational next-state logic.

Verification
REQ-035 Reset, ihit=1 every cycle, imemload=0x20010005: after 3 edges PC=0xC, nPCIn=0xC, valid=1.
REQ-036 PC=0x40, redirect=1, PCSrc=0x100, ihit=1: next PC=0x100; flush next cycle -> valid=0, instru=0.
REQ-037 PC=0x40, ihit=0, redirect=1, PCSrc=0x200; ihit=1 two cycles later: state PEND then RUN, PC=0x200, valid=0 that edge.
REQ-038 stall=1 three cycles with ihit=1: PC, instru, nPCIn unchanged; stall=1 & flush=1: valid=0.
REQ-039 halt=1 at PC=0x80: imemREN=0, PC stays 0x80 ten cycles; nRST=0 -> PC=RESET_PC, imemREN=1.
REQ-040 RESET_PC=0xFFFFFFFC, ihit=1: next PC=0x00000000, nPCIn=0x00000000.
